// File: rtl/ecg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ecg_pkg
// Shared widths and FSM state encoding for the ECG feature-extraction stage.
// Revision : 1.0
// ============================================================================
package ecg_pkg;

  localparam int ECG_DATA_W   = 16;
  localparam int ECG_WIN_LOG2 = 6;

  function automatic int acc_width(input int data_w, input int win_log2);
    return data_w + win_log2;
  endfunction

  localparam int ECG_ACC_W = acc_width(ECG_DATA_W, ECG_WIN_LOG2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_ACC  = 2'd2,
    ST_OUT  = 2'd3
  } ecg_state_t;

endpackage
`default_nettype wire

// File: rtl/mwi_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mwi_ring_buffer
// Simple dual-port RAM holding the MWI window; synchronous read, no reset.
// Revision : 1.0
// ============================================================================
module mwi_ring_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ecg_sq_mwi_axis.sv
`default_nettype none
// ============================================================================
// Module   : ecg_sq_mwi_axis
// Pan-Tompkins 5-point derivative, squaring and moving-window integrator.
// Revision : 1.0
// ============================================================================
module ecg_sq_mwi_axis
  import ecg_pkg::*;
#(
  parameter int INOUT_WIDTH = ECG_DATA_W,
  parameter int DERIV_WIDTH = 19,
  parameter int SQ_SHIFT    = 20,
  parameter int WIN_LOG2    = ECG_WIN_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INOUT_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [INOUT_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int ACC_W  = acc_width(INOUT_WIDTH, WIN_LOG2);
  localparam int PROD_W = 2 * DERIV_WIDTH;
  localparam logic [PROD_W-1:0] E_MAX = PROD_W'({INOUT_WIDTH{1'b1}});

  ecg_state_t r_state;
  ecg_state_t w_state_nxt;
  logic       w_accept;

  logic signed [INOUT_WIDTH-1:0] r_x [0:4];
  logic signed [DERIV_WIDTH-1:0] w_deriv;
  logic signed [PROD_W-1:0]      w_deriv_ext;
  logic signed [PROD_W-1:0]      w_sq;
  logic        [PROD_W-1:0]      w_sq_shr;
  logic        [INOUT_WIDTH-1:0] w_e;
  logic        [INOUT_WIDTH-1:0] r_e;

  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       w_acc_nxt;
  logic [INOUT_WIDTH-1:0] w_ring_rd;
  logic [INOUT_WIDTH-1:0] w_old;
  logic [WIN_LOG2-1:0]    r_wr_ptr;
  logic                   r_fill_done;
  logic                   w_ring_wr_en;
  logic                   w_ring_rd_en;

  logic                   r_s_tready;
  logic                   r_m_tvalid;
  logic [INOUT_WIDTH-1:0] r_m_tdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s_tready && s_axis_tvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SQ;
        end
      end
      ST_SQ:   w_state_nxt = ST_ACC;
      ST_ACC:  w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (m_axis_tready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Exact derivative (no /8); the square is nonnegative so the top bits stay zero.
  assign w_deriv = (DERIV_WIDTH'(r_x[0]) <<< 1) + DERIV_WIDTH'(r_x[1])
                 - DERIV_WIDTH'(r_x[3]) - (DERIV_WIDTH'(r_x[4]) <<< 1);
  assign w_deriv_ext = PROD_W'(w_deriv);
  assign w_sq        = w_deriv_ext * w_deriv_ext;
  assign w_sq_shr    = $unsigned(w_sq) >> SQ_SHIFT;
  assign w_e         = (w_sq_shr > E_MAX) ? {INOUT_WIDTH{1'b1}} : w_sq_shr[INOUT_WIDTH-1:0];

  assign w_ring_rd_en = (r_state == ST_SQ);
  assign w_ring_wr_en = (r_state == ST_ACC);
  assign w_old        = r_fill_done ? w_ring_rd : '0;
  assign w_acc_nxt    = r_acc + ACC_W'(r_e) - ACC_W'(w_old);

  mwi_ring_buffer #(
    .DATA_W(INOUT_WIDTH),
    .ADDR_W(WIN_LOG2)
  ) u_ring (
    .clk      (clk),
    .i_wr_en  (w_ring_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(r_e),
    .i_rd_en  (w_ring_rd_en),
    .i_rd_addr(r_wr_ptr),
    .o_rd_data(w_ring_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_x[i] <= '0;
      end
      r_e         <= '0;
      r_acc       <= '0;
      r_wr_ptr    <= '0;
      r_fill_done <= 1'b0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
    end else begin
      r_s_tready <= (w_state_nxt == ST_IDLE);
      r_m_tvalid <= (w_state_nxt == ST_OUT);
      if (w_accept) begin
        r_x[0] <= s_axis_tdata;
        for (int i = 1; i < 5; i++) begin
          r_x[i] <= r_x[i-1];
        end
      end
      if (r_state == ST_SQ) begin
        r_e <= w_e;
      end
      if (r_state == ST_ACC) begin
        r_acc     <= w_acc_nxt;
        r_m_tdata <= w_acc_nxt[ACC_W-1:WIN_LOG2];
        r_wr_ptr  <= r_wr_ptr + WIN_LOG2'(1);
        // Once the pointer has wrapped, every slot holds a live window entry.
        if (r_wr_ptr == '1) begin
          r_fill_done <= 1'b1;
        end
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;

endmodule
`default_nettype wire
